// File: rtl/reg_seg_display.sv
// Eight-digit multiplexed seven-segment viewer for a register index/data pair.
// Optional macro REG_SEG_ADDR_OVERLAY_EN shows the register index on digits 7..6.
module reg_seg_display #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DIV_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  reg_addr,
    input  logic [31:0] reg_data,
    input  logic        load,
    input  logic        freeze,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [2:0]       idx;
    logic [31:0]      data_sh;
    logic [4:0]       addr_sh;

    logic [3:0]       nib_p0;
    logic [7:0]       an_p0;
    logic [6:0]       seg_p0;
    logic             dp_p0;

    logic [7:0]       an_p1;
    logic [6:0]       seg_p1;
    logic             dp_p1;

    // Active-low segment pattern, bit order g..a.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= 3'd0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                idx <= idx + 3'd1;
            end
        end
    end

    // Shadows decouple the display from the live selector bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sh <= '0;
            addr_sh <= '0;
        end else if (load && !freeze) begin
            data_sh <= reg_data;
            addr_sh <= reg_addr;
        end
    end

    // Stage p0: digit select and decode from current idx and shadows.
    always_comb begin
        nib_p0 = data_sh[{idx, 2'b00} +: 4];
        dp_p0  = 1'b1;
`ifdef REG_SEG_ADDR_OVERLAY_EN
        if (idx == 3'd7) begin
            nib_p0 = {3'b000, addr_sh[4]};
        end else if (idx == 3'd6) begin
            nib_p0 = addr_sh[3:0];
            dp_p0  = 1'b0;
        end
`endif
        an_p0  = ~(8'b1 << idx);
        seg_p0 = hex7(nib_p0);
    end

`ifndef REG_SEG_ADDR_OVERLAY_EN
    logic unused_addr_sh;
    assign unused_addr_sh = ^addr_sh;
`endif

    // Stage p1: registered pad drivers; reset blanks the display asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_p1  <= 8'hFF;
            seg_p1 <= 7'h7F;
            dp_p1  <= 1'b1;
        end else begin
            an_p1  <= an_p0;
            seg_p1 <= seg_p0;
            dp_p1  <= dp_p0;
        end
    end

    assign an  = an_p1;
    assign seg = seg_p1;
    assign dp  = dp_p1;

endmodule

// File: tb/tb_reg_seg_display.sv
// Scoreboard bench for reg_seg_display: one instance at SCAN_DIV=4, one at SCAN_DIV=1.
module tb_reg_seg_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        load;
    logic        freeze;
    logic [7:0]  an4, an1;
    logic [6:0]  seg4, seg1;
    logic        dp4, dp1;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;
    int   n_vec = 0;
    int   n_err = 0;

    logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          m_cnt4;
    logic [2:0]  m_idx4, m_idx1;
    logic [31:0] m_data;
`ifdef REG_SEG_ADDR_OVERLAY_EN
    logic [4:0]  m_addr;
`endif

    reg_seg_display #(.SCAN_DIV(4), .DIV_W(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .reg_data(reg_data),
        .load(load), .freeze(freeze), .an(an4), .seg(seg4), .dp(dp4));

    reg_seg_display #(.SCAN_DIV(1), .DIV_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .reg_data(reg_data),
        .load(load), .freeze(freeze), .an(an1), .seg(seg1), .dp(dp1));

    always #5 clk = ~clk;

    function automatic exp_t model_out(input logic [2:0] i, input logic [31:0] d);
        exp_t       e;
        logic [3:0] nib;
        nib  = d[int'(i) * 4 +: 4];
        e.dp = 1'b1;
`ifdef REG_SEG_ADDR_OVERLAY_EN
        if (i == 3'd7) nib = {3'b000, m_addr[4]};
        if (i == 3'd6) begin
            nib  = m_addr[3:0];
            e.dp = 1'b0;
        end
`endif
        e.idx = i;
        e.an  = ~(8'b1 << i);
        e.seg = HEX[nib];
        return e;
    endfunction

    task automatic model_reset();
        m_cnt4 = 0;
        m_idx4 = 3'd0;
        m_idx1 = 3'd0;
        m_data = '0;
`ifdef REG_SEG_ADDR_OVERLAY_EN
        m_addr = '0;
`endif
        q4.delete();
        q1.delete();
    endtask

    // Push expectations for the coming edge, advance the model, step one clock.
    task automatic cycle();
        q4.push_back(model_out(m_idx4, m_data));
        q1.push_back(model_out(m_idx1, m_data));
        if (load && !freeze) begin
            m_data = reg_data;
`ifdef REG_SEG_ADDR_OVERLAY_EN
            m_addr = reg_addr;
`endif
        end
        if (m_cnt4 == 3) begin
            m_cnt4 = 0;
            m_idx4 = m_idx4 + 3'd1;
        end else begin
            m_cnt4 = m_cnt4 + 1;
        end
        m_idx1 = m_idx1 + 3'd1;
        @(posedge clk);
        #1;
        e4 = q4.pop_front();
        e1 = q1.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; freeze = 1'b0; reg_addr = '0; reg_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({an4, seg4, dp4, an1, seg1, dp1} !== {8'hFF, 7'h7F, 1'b1, 8'hFF, 7'h7F, 1'b1}) begin
            n_err++;
            $display("FAIL reset_hold got an=%h seg=%h dp=%b / an=%h seg=%h dp=%b want FF 7F 1", an4, seg4, dp4, an1, seg1, dp1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        n_vec++;
        if ({an4, seg4, an1, seg1} !== {8'hFE, 7'h40, 8'hFE, 7'h40}) begin
            n_err++;
            $display("FAIL reset_release got an=%h seg=%h / an=%h seg=%h want FE 40", an4, seg4, an1, seg1);
        end
        reg_data = 32'h0123_4567; load = 1'b1;
        cycle();
        load = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            n_vec++;
            if ({an4, seg4, dp4} !== {e4.an, e4.seg, e4.dp}) begin
                n_err++;
                $display("FAIL pre_reset_scan got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", an4, seg4, dp4, e4.an, e4.seg, e4.dp);
            end
        end
        rst_n = 1'b0;
        #2;
        n_vec++;
        if ({an4, seg4, dp4, an1, seg1, dp1} !== {8'hFF, 7'h7F, 1'b1, 8'hFF, 7'h7F, 1'b1}) begin
            n_err++;
            $display("FAIL reset_async got an=%h seg=%h dp=%b / an=%h seg=%h dp=%b want FF 7F 1", an4, seg4, dp4, an1, seg1, dp1);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        n_vec++;
        if ({an4, seg4, an1, seg1} !== {8'hFE, 7'h40, 8'hFE, 7'h40}) begin
            n_err++;
            $display("FAIL reset_rerelease got an=%h seg=%h / an=%h seg=%h want FE 40", an4, seg4, an1, seg1);
        end
    endtask

    task automatic test_scan();
        reg_data = 32'h0123_4567; load = 1'b1;
        cycle();
        load = 1'b0;
        for (int k = 0; k < 72; k++) begin
            cycle();
            n_vec++;
            if ({an4, seg4, dp4} !== {e4.an, e4.seg, e4.dp} || $countones(~an4) != 1) begin
                n_err++;
                $display("FAIL scan got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", an4, seg4, dp4, e4.an, e4.seg, e4.dp);
            end
`ifdef REG_SEG_ADDR_OVERLAY_EN
            if (e4.idx < 3'd6) begin
`else
            begin
`endif
                n_vec++;
                if (seg4 !== HEX[7 - int'(e4.idx)]) begin
                    n_err++;
                    $display("FAIL scan_digit idx=%0d got seg=%h want %h", e4.idx, seg4, HEX[7 - int'(e4.idx)]);
                end
            end
        end
    endtask

    task automatic test_decode();
        logic [6:0] dec [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
        reg_data = 32'h89AB_CDEF; load = 1'b1;
        cycle();
        load = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            n_vec++;
            if ({an1, seg1, dp1} !== {e1.an, e1.seg, e1.dp}) begin
                n_err++;
                $display("FAIL decode got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", an1, seg1, dp1, e1.an, e1.seg, e1.dp);
            end
`ifdef REG_SEG_ADDR_OVERLAY_EN
            if (e1.idx < 3'd6) begin
`else
            begin
`endif
                n_vec++;
                if (seg1 !== dec[e1.idx]) begin
                    n_err++;
                    $display("FAIL decode_table idx=%0d got seg=%h want %h", e1.idx, seg1, dec[e1.idx]);
                end
            end
        end
    endtask

    task automatic test_freeze();
        reg_data = 32'h1111_1111; load = 1'b1;
        cycle();
        freeze = 1'b1; reg_data = 32'h2222_2222;
        for (int k = 0; k < 17; k++) begin
            cycle();
            n_vec++;
            if ({an4, seg4, dp4, an1, seg1, dp1} !== {e4.an, e4.seg, e4.dp, e1.an, e1.seg, e1.dp}
                || (e4.idx < 3'd6 && seg4 !== 7'h79)) begin
                n_err++;
                $display("FAIL freeze got seg=%h/%h want %h/%h", seg4, seg1, e4.seg, e1.seg);
            end
        end
        freeze = 1'b0;
        cycle();
        load = 1'b0;
        n_vec++;
        if (seg4 !== e4.seg || (e4.idx < 3'd6 && seg4 !== 7'h79)) begin
            n_err++;
            $display("FAIL unfreeze_edge got seg=%h want %h", seg4, e4.seg);
        end
        for (int k = 0; k < 8; k++) begin
            cycle();
            n_vec++;
            if (seg4 !== e4.seg || seg1 !== e1.seg || (e4.idx < 3'd6 && seg4 !== 7'h24)) begin
                n_err++;
                $display("FAIL unfreeze got seg=%h/%h want %h/%h", seg4, seg1, e4.seg, e1.seg);
            end
        end
    endtask

    task automatic test_back_to_back_tick();
        logic [2:0] pi;
        for (int k = 0; k < 4 && m_cnt4 != 3; k++) begin
            cycle();
            n_vec++;
            if ({an4, seg4} !== {e4.an, e4.seg}) begin
                n_err++;
                $display("FAIL tick_align got an=%h seg=%h want an=%h seg=%h", an4, seg4, e4.an, e4.seg);
            end
        end
        pi = m_idx4;
        reg_data = 32'hFFFF_FFFF; load = 1'b1;
        cycle();
        load = 1'b0;
        n_vec++;
        if ({an4, seg4} !== {e4.an, e4.seg} || an4 !== ~(8'b1 << pi) || (pi < 3'd6 && seg4 !== 7'h24)) begin
            n_err++;
            $display("FAIL tick_load_old got an=%h seg=%h want an=%h seg=%h", an4, seg4, e4.an, e4.seg);
        end
        cycle();
        n_vec++;
        if ({an4, seg4} !== {e4.an, e4.seg} || an4 !== ~(8'b1 << (pi + 3'd1))
            || (pi + 3'd1 < 3'd6 && seg4 !== 7'h0E)) begin
            n_err++;
            $display("FAIL tick_load_new got an=%h seg=%h want an=%h seg=%h", an4, seg4, e4.an, e4.seg);
        end
    endtask

`ifdef REG_SEG_ADDR_OVERLAY_EN
    task automatic test_overlay();
        logic [6:0] ov [8] = '{7'h21, 7'h21, 7'h46, 7'h46, 7'h03, 7'h03, 7'h21, 7'h79};
        reg_addr = 5'd29; reg_data = 32'hAABB_CCDD; load = 1'b1;
        cycle();
        load = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            n_vec++;
            if (seg1 !== ov[e1.idx] || dp1 !== (e1.idx != 3'd6) || an1 !== e1.an) begin
                n_err++;
                $display("FAIL overlay idx=%0d got seg=%h dp=%b want seg=%h dp=%b", e1.idx, seg1, dp1, ov[e1.idx], e1.idx != 3'd6);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout n_vec=%0d", n_vec);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan();
        test_decode();
        test_freeze();
        test_back_to_back_tick();
`ifdef REG_SEG_ADDR_OVERLAY_EN
        test_overlay();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
